// File: rtl/alarm_sequencer.sv
// alarm_sequencer: sequenced door-alarm controller for the switch/LED board.
// A six-state FSM adds an exit delay, an entry delay, a timed siren and a
// post-siren lockout. All raw switch inputs pass through 2-flop synchronizers.
//
// Ports:
//   clk_2      in   divided board clock, rising-edge active
//   reset_n    in   asynchronous active-low reset
//   arm_sw     in   arm switch, 1 requests armed
//   dia        in   1 = daytime, 0 = night (night forces an arm request)
//   porta      in   door sensor, 1 = open
//   siren      out  alarm output, high only while DISPARADO
//   armed      out  high in ARMADO, ENTRADA, DISPARADO, BLOQUEIO
//   state      out  FSM state code for the LCD
//   countdown  out  remaining delay ticks in timed states, else 0
//   trig_count out  siren activations, saturating at 15, cleared only by reset
module alarm_sequencer #(
  parameter int unsigned EXIT_DELAY  = 4,
  parameter int unsigned ENTRY_DELAY = 3,
  parameter int unsigned SIREN_TIME  = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             arm_sw,
  input  logic             dia,
  input  logic             porta,
  output logic             siren,
  output logic             armed,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] countdown,
  output logic [3:0]       trig_count
);

  localparam logic [2:0] ST_DESARMADO = 3'd0;
  localparam logic [2:0] ST_SAIDA     = 3'd1;
  localparam logic [2:0] ST_ARMADO    = 3'd2;
  localparam logic [2:0] ST_ENTRADA   = 3'd3;
  localparam logic [2:0] ST_DISPARADO = 3'd4;
  localparam logic [2:0] ST_BLOQUEIO  = 3'd5;

  // Counter reload values: a delay of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME - 1);

  logic             r_arm_meta, r_arm_s;
  logic             r_dia_meta, r_dia_s;
  logic             r_porta_meta, r_porta_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_trig;

  logic             w_arm_req;
  logic [2:0]       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_trig_inc;

  // Synchronizers; dia resets to 1 so a reset does not look like night.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_meta   <= 1'b0;
      r_arm_s      <= 1'b0;
      r_dia_meta   <= 1'b1;
      r_dia_s      <= 1'b1;
      r_porta_meta <= 1'b0;
      r_porta_s    <= 1'b0;
    end else begin
      r_arm_meta   <= arm_sw;
      r_arm_s      <= r_arm_meta;
      r_dia_meta   <= dia;
      r_dia_s      <= r_dia_meta;
      r_porta_meta <= porta;
      r_porta_s    <= r_porta_meta;
    end
  end

  assign w_arm_req = r_arm_s | ~r_dia_s;

  // Disarm overrides every state, including the unused codes 6 and 7.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_trig_inc = 1'b0;
    if (!w_arm_req) begin
      w_state_nx = ST_DESARMADO;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_DESARMADO: begin
          w_state_nx = ST_SAIDA;
          w_cnt_nx   = EXIT_LD;
        end
        ST_SAIDA: begin
          if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end else if (r_porta_s) begin
            // Door still open at the end of the exit delay: restart it.
            w_cnt_nx = EXIT_LD;
          end else begin
            w_state_nx = ST_ARMADO;
          end
        end
        ST_ARMADO: begin
          if (r_porta_s) begin
            w_state_nx = ST_ENTRADA;
            w_cnt_nx   = ENTRY_LD;
          end
        end
        ST_ENTRADA: begin
          if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end else begin
            w_state_nx = ST_DISPARADO;
            w_cnt_nx   = SIREN_LD;
            w_trig_inc = 1'b1;
          end
        end
        ST_DISPARADO: begin
          if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end else begin
            w_state_nx = ST_BLOQUEIO;
          end
        end
        ST_BLOQUEIO: begin
          if (!r_porta_s) begin
            w_state_nx = ST_ARMADO;
          end
        end
        default: begin
          w_state_nx = ST_DESARMADO;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_DESARMADO;
      r_cnt   <= '0;
      r_trig  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_trig_inc && (r_trig != 4'hF)) begin
        r_trig <= r_trig + 4'd1;
      end
    end
  end

  // Moore outputs decoded from registered state, so reset clears them at once.
  assign siren      = (r_state == ST_DISPARADO);
  assign armed      = (r_state == ST_ARMADO)    || (r_state == ST_ENTRADA) ||
                      (r_state == ST_DISPARADO) || (r_state == ST_BLOQUEIO);
  assign countdown  = ((r_state == ST_SAIDA) || (r_state == ST_ENTRADA) ||
                       (r_state == ST_DISPARADO)) ? r_cnt : '0;
  assign state      = r_state;
  assign trig_count = r_trig;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer. Table rows give raw inputs and the outputs
// expected once the FSM has acted on those inputs; because of the 2-flop
// synchronizers that happens two edges after the row's own edge, so the
// scoreboard queue holds three rows before comparing the oldest.
module tb_alarm_sequencer;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       arm_sw, dia, porta;
  logic       siren, armed;
  logic [2:0] state;
  logic [7:0] countdown;
  logic [3:0] trig_count;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_sequencer #(
    .EXIT_DELAY (4),
    .ENTRY_DELAY(3),
    .SIREN_TIME (8),
    .CNT_W      (8)
  ) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .arm_sw    (arm_sw),
    .dia       (dia),
    .porta     (porta),
    .siren     (siren),
    .armed     (armed),
    .state     (state),
    .countdown (countdown),
    .trig_count(trig_count)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic       arm;
    logic       dia;
    logic       porta;
    logic [2:0] st;
    logic       sir;
    logic       arm_o;
    logic [7:0] cnt;
    logic [3:0] trig;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic add(input logic a, input logic d, input logic p, input logic [2:0] st,
                     input logic sir, input logic ao, input logic [7:0] cnt, input logic [3:0] tr);
    vec_t v;
    v.arm = a; v.dia = d; v.porta = p; v.st = st; v.sir = sir; v.arm_o = ao;
    v.cnt = cnt; v.trig = tr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_vec(input vec_t e, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    chk({tag, ".state"},      int'(state),      int'(e.st));
    chk({tag, ".siren"},      int'(siren),      int'(e.sir));
    chk({tag, ".armed"},      int'(armed),      int'(e.arm_o));
    chk({tag, ".countdown"},  int'(countdown),  int'(e.cnt));
    chk({tag, ".trig_count"}, int'(trig_count), int'(e.trig));
  endtask

  // Clock until the target state is observed; counts siren-high samples.
  task automatic wait_for(input logic [2:0] s, input string name, output int sir_hi);
    int n;
    n = 0;
    sir_hi = 0;
    while (state !== s && n < 100) begin
      @(posedge clk_2); #1;
      n++;
      if (siren === 1'b1) sir_hi++;
    end
    chk(name, int'(state), int'(s));
  endtask

  initial begin
    int sh;
    int exp_trig;
    int row;

    // 0 = DESARMADO 1 = SAIDA 2 = ARMADO 3 = ENTRADA 4 = DISPARADO 5 = BLOQUEIO
    // idle, held
    repeat (3) add(0, 1, 0, 3'd0, 0, 0, 8'd0, 4'd0);
    // arm: exit delay 3,2,1,0 then ARMADO
    add(1, 1, 0, 3'd1, 0, 0, 8'd3, 4'd0);
    add(1, 1, 0, 3'd1, 0, 0, 8'd2, 4'd0);
    add(1, 1, 0, 3'd1, 0, 0, 8'd1, 4'd0);
    add(1, 1, 0, 3'd1, 0, 0, 8'd0, 4'd0);
    add(1, 1, 0, 3'd2, 0, 1, 8'd0, 4'd0);
    add(1, 1, 0, 3'd2, 0, 1, 8'd0, 4'd0);
    // door opens: entry 2,1,0, siren 8 cycles, lockout, door closes
    add(1, 1, 1, 3'd3, 0, 1, 8'd2, 4'd0);
    add(1, 1, 1, 3'd3, 0, 1, 8'd1, 4'd0);
    add(1, 1, 1, 3'd3, 0, 1, 8'd0, 4'd0);
    for (int c = 7; c >= 0; c--) add(1, 1, 1, 3'd4, 1, 1, 8'(c), 4'd1);
    add(1, 1, 1, 3'd5, 0, 1, 8'd0, 4'd1);
    add(1, 1, 1, 3'd5, 0, 1, 8'd0, 4'd1);
    add(1, 1, 0, 3'd2, 0, 1, 8'd0, 4'd1);
    add(1, 1, 0, 3'd2, 0, 1, 8'd0, 4'd1);
    // entry aborted by disarm at countdown 1
    add(1, 1, 1, 3'd3, 0, 1, 8'd2, 4'd1);
    add(1, 1, 1, 3'd3, 0, 1, 8'd1, 4'd1);
    add(0, 1, 1, 3'd0, 0, 0, 8'd0, 4'd1);
    add(0, 1, 0, 3'd0, 0, 0, 8'd0, 4'd1);
    // night auto-arm with door held open: exit delay restarts
    add(0, 0, 1, 3'd1, 0, 0, 8'd3, 4'd1);
    add(0, 0, 1, 3'd1, 0, 0, 8'd2, 4'd1);
    add(0, 0, 1, 3'd1, 0, 0, 8'd1, 4'd1);
    add(0, 0, 1, 3'd1, 0, 0, 8'd0, 4'd1);
    add(0, 0, 1, 3'd1, 0, 0, 8'd3, 4'd1);
    add(0, 0, 1, 3'd1, 0, 0, 8'd2, 4'd1);
    add(0, 0, 0, 3'd1, 0, 0, 8'd1, 4'd1);
    add(0, 0, 0, 3'd1, 0, 0, 8'd0, 4'd1);
    add(0, 0, 0, 3'd2, 0, 1, 8'd0, 4'd1);
    // daylight with switch off: disarm from ARMADO
    add(0, 1, 0, 3'd0, 0, 0, 8'd0, 4'd1);
    add(0, 1, 0, 3'd0, 0, 0, 8'd0, 4'd1);

    // reset with inputs at their idle values
    arm_sw = 1'b0; dia = 1'b1; porta = 1'b0;
    reset_n = 1'b0;
    #3;
    chk("reset.state",      int'(state),      0);
    chk("reset.siren",      int'(siren),      0);
    chk("reset.armed",      int'(armed),      0);
    chk("reset.countdown",  int'(countdown),  0);
    chk("reset.trig_count", int'(trig_count), 0);
    repeat (2) @(posedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b1;
    @(posedge clk_2); #1;

    // table-driven scoreboard
    row = 0;
    foreach (vecs[i]) begin
      arm_sw = vecs[i].arm;
      dia    = vecs[i].dia;
      porta  = vecs[i].porta;
      sb.push_back(vecs[i]);
      @(posedge clk_2); #1;
      if (sb.size() == 3) begin
        cmp_vec(sb.pop_front(), row);
        row++;
      end
    end
    while (sb.size() > 0) begin
      @(posedge clk_2); #1;
      cmp_vec(sb.pop_front(), row);
      row++;
    end

    // repeated triggers: counter saturates at 15
    exp_trig = 1;
    arm_sw = 1'b1; dia = 1'b1; porta = 1'b0;
    wait_for(3'd2, "sat.arm", sh);
    for (int k = 0; k < 16; k++) begin
      porta = 1'b1;
      wait_for(3'd5, "sat.lockout", sh);
      chk($sformatf("sat%0d.siren_len", k), sh, 8);
      exp_trig = (exp_trig < 15) ? exp_trig + 1 : 15;
      chk($sformatf("sat%0d.trig_count", k), int'(trig_count), exp_trig);
      porta = 1'b0;
      wait_for(3'd2, "sat.rearm", sh);
      chk("sat.rearm_siren", int'(siren), 0);
    end
    chk("sat.final", int'(trig_count), 15);

    // asynchronous reset in the middle of the siren
    porta = 1'b1;
    wait_for(3'd4, "rst.fire", sh);
    @(posedge clk_2); #3;
    chk("rst.pre_siren", int'(siren), 1);
    reset_n = 1'b0;
    #1;
    chk("rst.siren",      int'(siren),      0);
    chk("rst.trig_count", int'(trig_count), 0);
    chk("rst.state",      int'(state),      0);
    chk("rst.armed",      int'(armed),      0);
    chk("rst.countdown",  int'(countdown),  0);
    arm_sw = 1'b0; dia = 1'b1; porta = 1'b0;
    @(negedge clk_2);
    reset_n = 1'b1;
    repeat (4) @(posedge clk_2);
    #1;
    chk("post_rst.state", int'(state),      0);
    chk("post_rst.trig",  int'(trig_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
